// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Optional early-out for multiplies is enabled by MULDIV_EARLY_OUT_EN.
package ex_muldiv_sequencer_pkg;

  localparam int MULDIV_STEPS = 32;
  localparam int CNT_W        = 5;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_STEPS - 1);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_type;

  function automatic logic op_signed_a(input muldiv_op_type o);
    return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic op_signed_b(input muldiv_op_type o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_muldiv_iter_core.sv
// Iterative datapath: 64-bit shift-add multiplier and restoring divider on shared registers.
// Operands arrive as magnitudes; sign handling is done by the sequencer.
module muldiv_iter_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [63:0] product,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        mplier_last
);

  // mul: acc = product, mcand = shifted multiplicand, mplier = remaining multiplier bits
  // div: acc[31:0] = partial remainder, mcand[31:0] = divisor, mplier = dividend -> quotient
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;

  logic [32:0] shifted;
  logic [31:0] diff_lo;
  logic        ge;

  always_comb begin
    shifted = {acc_q[31:0], mplier_q[31]};
    ge      = shifted >= {1'b0, mcand_q[31:0]};
    diff_lo = shifted[31:0] - mcand_q[31:0];

    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {32'd0, (is_div ? b_mag : a_mag)};
      mplier_d = is_div ? a_mag : b_mag;
    end else if (step) begin
      if (is_div) begin
        acc_d    = {32'd0, (ge ? diff_lo : shifted[31:0])};
        mplier_d = {mplier_q[30:0], ge};
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign product     = acc_q;
  assign quotient    = mplier_q;
  assign remainder   = acc_q[31:0];
  assign mplier_last = (mplier_q[31:1] == 31'd0);

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer: FSM, step counter, special cases, sign fix.
// Define MULDIV_EARLY_OUT_EN to let multiplies leave CALC once the multiplier is exhausted.
//
//  state | meaning
//  IDLE  | waiting for start; accepts op, loads core or latches a special-case result
//  CALC  | one core iteration per cycle, counter 31..0
//  FIX   | sign correction and word select into result register
//  DONE  | result_valid pulse; pipeline released
module ex_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);
  import ex_muldiv_sequencer_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic EARLY_EN = 1'b1;
`else
  localparam logic EARLY_EN = 1'b0;
`endif

  muldiv_state_type state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  muldiv_op_type    op_q, op_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [31:0]      result_q, result_d;

  muldiv_op_type op_in;
  logic          sign_a, sign_b, div_zero, div_ovf, special, accept;
  logic [31:0]   a_mag, b_mag, special_res, fix_result;
  logic [63:0]   product, prod_fixed;
  logic [31:0]   quotient, remainder;
  logic          core_load, core_step, core_is_div, mplier_last, early;

  always_comb begin
    op_in    = muldiv_op_type'(op);
    sign_a   = operand_a[31] & op_signed_a(op_in);
    sign_b   = operand_b[31] & op_signed_b(op_in);
    a_mag    = sign_a ? -operand_a : operand_a;
    b_mag    = sign_b ? -operand_b : operand_b;
    div_zero = op[2] & (operand_b == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (operand_a == 32'h8000_0000) && (&operand_b);
    special  = div_zero | div_ovf;
    // op[1] distinguishes REM*/REMU from DIV*/DIVU
    if (div_zero) special_res = op[1] ? operand_a : 32'hFFFF_FFFF;
    else          special_res = op[1] ? 32'd0 : 32'h8000_0000;
    accept   = (state_q == IDLE) & start & ~flush;
  end

  assign core_load   = accept & ~special;
  assign core_step   = (state_q == CALC);
  assign core_is_div = (state_q == IDLE) ? op[2] : op_q[2];
  assign early       = EARLY_EN & ~op_q[2] & mplier_last;

  muldiv_iter_core u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (core_load),
    .step        (core_step),
    .is_div      (core_is_div),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .product     (product),
    .quotient    (quotient),
    .remainder   (remainder),
    .mplier_last (mplier_last)
  );

  always_comb begin
    prod_fixed = neg_q ? (64'd0 - product) : product;
    case (op_q)
      OP_MUL:                        fix_result = prod_fixed[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fixed[63:32];
      OP_DIV, OP_DIVU:               fix_result = neg_q ? -quotient : quotient;
      default:                       fix_result = rem_neg_q ? -remainder : remainder;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = op_in;
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            counter_d = CNT_LOAD;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if ((counter_q == '0) || early) state_d = FIX;
        else                            counter_d = counter_q - 1'b1;
      end
      FIX: begin
        result_d = fix_result;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

  assign stall        = accept | (state_q == CALC) | (state_q == FIX);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: directed RV32M vectors, latency, flush and reset.
// Expected multiply latency follows MULDIV_EARLY_OUT_EN when the bench is built with it.
module tb_ex_muldiv_sequencer;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_pulses = 0;

  ex_muldiv_sequencer #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mul_lat(input logic [31:0] bmag);
    int n;
    n = 1;
    for (int i = 1; i < 32; i++) if (bmag[i]) n = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
    return n + 2;
`else
    return (n > 0) ? 34 : 34;
`endif
  endfunction

  // monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (result_valid) begin
      exp_t e;
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: result %h with empty scoreboard", result);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("result_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // drives one op from the current cycle; returns one cycle after DONE with start still high
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int lat);
    int n_stall;
    bit seen;
    exp_q.push_back('{res: r, cyc: cyc + lat});
    n_pushed++;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    n_stall = 0;
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (result_valid) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: op %0d got no result_valid within 80 cycles", o);
    end
    chk("stall_cycles", 32'(n_stall), 32'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] prev;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; operand_a = '0; operand_b = '0;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(MUL,    32'd7,        32'd6,        32'h0000_002A, mul_lat(32'd6));
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, mul_lat(32'hFFFF_FFFF));
    run_op(MULH,   32'hFFFF_FFFD, 32'd2,        32'hFFFF_FFFF, mul_lat(32'd2));
    run_op(MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, mul_lat(32'd2));
    run_op(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, mul_lat(32'hFFFF_FFFF));
    run_op(DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
    run_op(REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
    run_op(DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op(REM,    32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 34);
    run_op(REMU,   32'd100,      32'd7,        32'd2,         34);
    run_op(DIVU,   32'd10,       32'd0,        32'hFFFF_FFFF, 1);
    run_op(REMU,   32'd10,       32'd0,        32'd10,        1);
    run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op(DIVU,   32'd100,      32'd7,        32'd14,        34);
    start = 1'b0;
    prev = 32'd14;
    @(posedge clk); #1;

    // flush in cycle 10 of a divide
    op = DIV; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1; start = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_result_kept", result, prev);
    repeat (40) @(posedge clk);
    #1;

    // reset in cycle 20 of a divide
    op = DIVU; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b0;
    #1;
    chk("areset_result", result, 32'd0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_valid", {31'd0, result_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // early-out candidate and back-to-back ops with start held high
    run_op(MUL,    32'd5,        32'd1,        32'd5,         mul_lat(32'd1));
    run_op(DIVU,   32'd9,        32'd2,        32'd4,         34);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("pulse_count", 32'(n_pulses), 32'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
